// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution sequencer.
// Holds the FSM state encoding and the parameter-derived address/kernel widths.
// Imported by conv_sequencer and conv_mac.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MAC      = 3'd1,
    S_DRAIN    = 3'd2,
    S_OUT      = 3'd3,
    S_DONE     = 3'd4,
    S_WAIT_CLR = 3'd5
  } conv_state_t;

  function automatic int k_bits(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int x_addr_bits(input int r, input int c);
    return $clog2(r * c);
  endfunction

  function automatic int w_addr_bits(input int maxk);
    return $clog2(maxk * maxk);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: acc <= (first ? sext(bias) : acc) + sext(a*b) when en.
// Latency: 1 cycle from operands to updated accumulator.
// No backpressure: the caller gates en; accumulator holds while en is low.
module conv_mac
  import conv_pkg::*;
#(
  parameter int INW  = 24,
  parameter int OUTW = 48
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en_i,
  input  logic                   first_i,
  input  logic signed [INW-1:0]  bias_i,
  input  logic signed [INW-1:0]  a_i,
  input  logic signed [INW-1:0]  b_i,
  output logic signed [OUTW-1:0] acc_o
);

  logic signed [2*INW-1:0] prod;
  logic signed [OUTW-1:0]  base;
  logic signed [OUTW-1:0]  acc_q;
  logic signed [OUTW-1:0]  acc_d;

  // Full-precision product, then restart from the bias or keep summing; wraps modulo 2^OUTW.
  always_comb begin
    prod  = (2*INW)'(a_i) * (2*INW)'(b_i);
    base  = first_i ? OUTW'(bias_i) : acc_q;
    acc_d = base + OUTW'(prod);
  end

  // Accumulator register, only advances on a valid data beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_sequencer.sv
// Walks X/W read ports to compute each valid-position convolution result and streams it over AXIS.
// Latency: K*K+2 cycles per result with TREADY high; compute_finished one cycle after the last beat.
// Backpressure: S_OUT holds TDATA/TLAST stable until TREADY; no compute runs ahead of the output.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int INW         = 24,
  parameter int OUTW        = 48,
  parameter int R           = 9,
  parameter int C           = 8,
  parameter int MAXK        = 4,
  parameter int K_BITS      = k_bits(MAXK),
  parameter int X_ADDR_BITS = x_addr_bits(R, C),
  parameter int W_ADDR_BITS = w_addr_bits(MAXK)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic [INW-1:0]         B,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  input  logic [INW-1:0]         X_data,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  input  logic [INW-1:0]         W_data,
  output logic                   compute_finished,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  output logic                   AXIS_TLAST,
  input  logic                   AXIS_TREADY
);

  localparam int IW = $clog2(R + 1);
  localparam int JW = $clog2(C + 1);

  conv_state_t state_q, state_d;
  logic [K_BITS-1:0] k_r_q;
  logic [INW-1:0]    b_r_q;
  logic [IW-1:0]     i_q;
  logic [JW-1:0]     j_q;
  logic [K_BITS-1:0] kc_q;
  logic [K_BITS-1:0] lc_q;
  logic              d_vld_q;
  logic              d_first_q;

  logic                   k_ok;
  logic                   l_wrap;
  logic                   mac_last;
  logic                   j_wrap;
  logic                   out_last;
  logic                   hs;
  logic signed [OUTW-1:0] acc;

  assign k_ok     = (K != '0) && (int'(K) <= MAXK);
  assign l_wrap   = (lc_q == k_r_q - K_BITS'(1));
  assign mac_last = l_wrap && (kc_q == k_r_q - K_BITS'(1));
  assign j_wrap   = (int'(j_q) == C - int'(k_r_q));
  assign out_last = j_wrap && (int'(i_q) == R - int'(k_r_q));
  assign hs       = (state_q == S_OUT) && AXIS_TREADY;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; an out-of-range kernel skips straight to the finish pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (inputs_loaded) state_d = k_ok ? S_MAC : S_DONE;
      S_MAC:      if (mac_last) state_d = S_DRAIN;
      S_DRAIN:    state_d = S_OUT;
      S_OUT:      if (hs) state_d = out_last ? S_DONE : S_MAC;
      S_DONE:     state_d = S_WAIT_CLR;
      S_WAIT_CLR: if (!inputs_loaded) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Operand capture, window counters and the one-cycle-delayed data-valid pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_r_q     <= '0;
      b_r_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      kc_q      <= '0;
      lc_q      <= '0;
      d_vld_q   <= 1'b0;
      d_first_q <= 1'b0;
    end else begin
      d_vld_q   <= (state_q == S_MAC);
      d_first_q <= (state_q == S_MAC) && (kc_q == '0) && (lc_q == '0);
      unique case (state_q)
        S_IDLE: if (inputs_loaded) begin
          k_r_q <= K;
          b_r_q <= B;
          i_q   <= '0;
          j_q   <= '0;
          kc_q  <= '0;
          lc_q  <= '0;
        end
        S_MAC: begin
          if (l_wrap) begin
            lc_q <= '0;
            kc_q <= kc_q + K_BITS'(1);
          end else begin
            lc_q <= lc_q + K_BITS'(1);
          end
        end
        S_OUT: if (hs && !out_last) begin
          kc_q <= '0;
          lc_q <= '0;
          if (j_wrap) begin
            j_q <= '0;
            i_q <= i_q + IW'(1);
          end else begin
            j_q <= j_q + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  conv_mac #(.INW(INW), .OUTW(OUTW)) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (d_vld_q),
    .first_i (d_first_q),
    .bias_i  (b_r_q),
    .a_i     (X_data),
    .b_i     (W_data),
    .acc_o   (acc)
  );

  // Outputs decoded from state: addresses only while issuing, AXIS only in S_OUT.
  always_comb begin
    X_read_addr      = '0;
    W_read_addr      = '0;
    AXIS_TVALID      = 1'b0;
    AXIS_TDATA       = '0;
    AXIS_TLAST       = 1'b0;
    compute_finished = 1'b0;
    unique case (state_q)
      S_MAC: begin
        X_read_addr = X_ADDR_BITS'((int'(i_q) + int'(kc_q)) * C + int'(j_q) + int'(lc_q));
        W_read_addr = W_ADDR_BITS'(int'(kc_q) * int'(k_r_q) + int'(lc_q));
      end
      S_OUT: begin
        AXIS_TVALID = 1'b1;
        AXIS_TDATA  = acc;
        AXIS_TLAST  = out_last;
      end
      S_DONE:  compute_finished = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Table-driven bench with a result scoreboard, plus hand-written reset and stale-start sequences.
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int INW  = 24;
  localparam int OUTW = 48;
  localparam int R    = 9;
  localparam int C    = 8;
  localparam int MAXK = 4;
  localparam int KB   = k_bits(MAXK);
  localparam int XAB  = x_addr_bits(R, C);
  localparam int WAB  = w_addr_bits(MAXK);
  localparam int XN   = 1 << XAB;
  localparam int WN   = 1 << WAB;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            inputs_loaded;
  logic [KB-1:0]   K;
  logic [INW-1:0]  B;
  logic [XAB-1:0]  X_read_addr;
  logic [INW-1:0]  X_data;
  logic [WAB-1:0]  W_read_addr;
  logic [INW-1:0]  W_data;
  logic            compute_finished;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TLAST;
  logic            AXIS_TREADY;

  conv_sequencer #(.INW(INW), .OUTW(OUTW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .inputs_loaded    (inputs_loaded),
    .K                (K),
    .B                (B),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data),
    .compute_finished (compute_finished),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TLAST       (AXIS_TLAST),
    .AXIS_TREADY      (AXIS_TREADY)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle of latency like the real block.
  logic signed [INW-1:0] x_mem [XN];
  logic signed [INW-1:0] w_mem [WN];
  always @(posedge clk) begin
    X_data <= x_mem[X_read_addr];
    W_data <= w_mem[W_read_addr];
  end

  typedef struct {
    logic [KB-1:0]          k;
    logic signed [INW-1:0]  b;
    int                     xm;
    int                     wm;
    int                     rm;
    int                     n;
    bit                     uni;
    logic signed [OUTW-1:0] val;
    string                  nm;
  } vec_t;

  typedef struct packed {
    logic [OUTW-1:0] d;
    logic            l;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   rx_cnt = 0;
  int   fin_cnt = 0;
  int   rdy_mode = 0;
  int   cur_k = 0;
  int   ncyc = 0;
  int   last_hs = -1;
  bit   held_vld = 1'b0;
  logic [OUTW-1:0] held_dat;
  logic held_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input int b, input int xm, input int wm, input int rm,
                              input int n, input bit uni, input logic signed [OUTW-1:0] val,
                              input string nm);
    vec_t v;
    v.k = KB'(k); v.b = INW'(b); v.xm = xm; v.wm = wm; v.rm = rm;
    v.n = n; v.uni = uni; v.val = val; v.nm = nm;
    return v;
  endfunction

  // Direct reference convolution over the bench's own memory images.
  function automatic logic signed [OUTW-1:0] ref_y(input int kk, input int ii, input int jj,
                                                   input logic signed [INW-1:0] bb);
    logic signed [OUTW-1:0]  s;
    logic signed [2*INW-1:0] p;
    logic signed [2*INW-1:0] xv;
    logic signed [2*INW-1:0] wv;
    s = OUTW'(bb);
    for (int a = 0; a < kk; a++)
      for (int c = 0; c < kk; c++) begin
        xv = (2*INW)'(x_mem[(ii + a) * C + jj + c]);
        wv = (2*INW)'(w_mem[a * kk + c]);
        p  = xv * wv;
        s  = s + OUTW'(p);
      end
    return s;
  endfunction

  task automatic load_mem(input int xm, input int wm);
    for (int a = 0; a < XN; a++) begin
      x_mem[a] = '0;
      if (a < R * C)
        case (xm)
          1:       x_mem[a] = 24'sd1;
          2:       x_mem[a] = INW'((a / C) * 8 + (a % C));
          3:       x_mem[a] = 24'sh7FFFFF;
          default: x_mem[a] = '0;
        endcase
    end
    for (int a = 0; a < WN; a++)
      case (wm)
        1:       w_mem[a] = 24'sd1;
        2:       w_mem[a] = (a == 4) ? 24'sd1 : 24'sd0;
        3:       w_mem[a] = 24'shFFFFFF;
        4:       w_mem[a] = INW'(a - 7);
        default: w_mem[a] = '0;
      endcase
  endtask

  task automatic push_expected(input vec_t v);
    int kk;
    kk = int'(v.k);
    q.delete();
    if (kk >= 1 && kk <= MAXK)
      for (int i = 0; i <= R - kk; i++)
        for (int j = 0; j <= C - kk; j++)
          q.push_back('{d: (v.uni ? v.val : ref_y(kk, i, j, v.b)),
                        l: (i == R - kk && j == C - kk)});
  endtask

  // TREADY pattern, changed just after each rising edge.
  initial begin
    int ph;
    ph = 0;
    AXIS_TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      case (rdy_mode)
        0:       AXIS_TREADY = 1'b1;
        1:       AXIS_TREADY = (ph == 0);
        default: AXIS_TREADY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: stall stability, scoreboard pop, beat spacing, finish pulses.
  always @(negedge clk) begin
    ncyc++;
    if (!reset_n) begin
      held_vld = 1'b0;
    end else begin
      if (compute_finished) fin_cnt++;
      if (held_vld) begin
        chk("stall_tvalid", 64'(AXIS_TVALID), 64'd1);
        chk("stall_tdata", 64'(AXIS_TDATA), 64'(held_dat));
        chk("stall_tlast", 64'(AXIS_TLAST), 64'(held_last));
      end
      if (AXIS_TVALID && AXIS_TREADY) begin
        if (q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL extra_result: got beat %0d data %0h want no beat", rx_cnt, AXIS_TDATA);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("tdata", 64'(AXIS_TDATA), 64'(e.d));
          chk("tlast", 64'(AXIS_TLAST), 64'(e.l));
        end
        if (rdy_mode == 0 && rx_cnt > 0)
          chk("beat_gap", 64'(ncyc - last_hs), 64'(cur_k * cur_k + 2));
        last_hs = ncyc;
        rx_cnt++;
      end
      held_vld  = AXIS_TVALID && !AXIS_TREADY;
      held_dat  = AXIS_TDATA;
      held_last = AXIS_TLAST;
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc;
    load_mem(v.xm, v.wm);
    push_expected(v);
    rdy_mode = v.rm;
    cur_k    = int'(v.k);
    rx_cnt   = 0;
    fin_cnt  = 0;
    @(negedge clk);
    K = v.k;
    B = v.b;
    inputs_loaded = 1'b1;
    cyc = 0;
    while (fin_cnt == 0 && cyc < 5000) begin
      @(posedge clk);
      #2;
      cyc++;
      if (cyc == 1) begin
        K = v.k + KB'(1);
        B = ~v.b;
      end
    end
    chk({v.nm, "_finish_seen"}, 64'(fin_cnt), 64'd1);
    if (v.n == 0) chk({v.nm, "_finish_latency"}, 64'(cyc <= 3), 64'd1);
    // Stale inputs_loaded must not trigger a second operation.
    repeat (8) @(posedge clk);
    #2;
    chk({v.nm, "_single_finish"}, 64'(fin_cnt), 64'd1);
    chk({v.nm, "_result_count"}, 64'(rx_cnt), 64'(v.n));
    chk({v.nm, "_queue_empty"}, 64'(q.size()), 64'd0);
    chk({v.nm, "_idle_tvalid"}, 64'(AXIS_TVALID), 64'd0);
    inputs_loaded = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid();
    int cyc;
    load_mem(2, 1);
    push_expected(mk(2, 0, 2, 1, 0, 56, 0, '0, "rst"));
    rdy_mode = 0;
    cur_k    = 2;
    rx_cnt   = 0;
    fin_cnt  = 0;
    @(negedge clk);
    K = 2;
    B = '0;
    inputs_loaded = 1'b1;
    cyc = 0;
    while (rx_cnt < 9 && cyc < 2000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("rst_reach_result10", 64'(rx_cnt), 64'd9);
    // First issue of result index 9: window origin (1,2) -> X address 1*8+2.
    chk("rst_pre_xaddr", 64'(X_read_addr), 64'd10);
    #1;
    reset_n = 1'b0;
    inputs_loaded = 1'b0;
    #1;
    chk("rst_async_tvalid", 64'(AXIS_TVALID), 64'd0);
    chk("rst_async_finish", 64'(compute_finished), 64'd0);
    chk("rst_async_xaddr", 64'(X_read_addr), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_no_finish", 64'(fin_cnt), 64'd0);
    q.delete();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = mk(2, 0, 1, 1, 0, 56, 1, 48'sd4, "k2_ones");
    tbl[1] = mk(3, 5, 2, 2, 0, 42, 0, '0, "k3_center");
    tbl[2] = mk(2, 0, 2, 1, 1, 56, 0, '0, "k2_stall");
    tbl[3] = mk(4, -1, 3, 3, 0, 30, 1, -48'sd134217713, "k4_extreme");
    tbl[4] = mk(0, 0, 1, 1, 0, 0, 0, '0, "k0_skip");
    tbl[5] = mk(1, -3, 2, 4, 2, 72, 0, '0, "k1_mixed");
    tbl[6] = mk(5, 0, 1, 1, 0, 0, 0, '0, "k5_oversize");
    tbl[7] = mk(4, 1000, 2, 4, 2, 30, 0, '0, "k4_random_ready");

    reset_n = 1'b0;
    inputs_loaded = 1'b0;
    K = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tvalid", 64'(AXIS_TVALID), 64'd0);
    chk("reset_tdata", 64'(AXIS_TDATA), 64'd0);
    chk("reset_tlast", 64'(AXIS_TLAST), 64'd0);
    chk("reset_finish", 64'(compute_finished), 64'd0);
    chk("reset_xaddr", 64'(X_read_addr), 64'd0);
    chk("reset_waddr", 64'(W_read_addr), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 8; t++) run_vec(tbl[t]);

    reset_mid();
    run_vec(mk(2, 0, 2, 1, 0, 56, 0, '0, "after_reset"));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
